// File: rtl/counter_updn_param.sv
// Parameterised up/down counter with a prescaler, selectable terminal behaviour
// (wrap, saturate, one-shot) and a registered terminal-event pulse.
module counter_updn_param #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] L,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             D,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] Q,
  output logic             Z_carry,
  output logic             DONE,
  output logic             state_o
);

  typedef enum logic {
    RUN  = 1'b0,
    STOP = 1'b1
  } state_t;

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             z_q, z_d;
  logic             done_q, done_d;
  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;
  logic             terminal;

  assign tick = EN && (presc_q == PMAX);

  always_comb begin
    q_d      = q_q;
    z_d      = 1'b0;
    done_d   = done_q;
    state_d  = state_q;
    presc_d  = presc_q;
    terminal = 1'b0;

    // The prescaler keeps running in STOP; only the resulting ticks are ignored.
    if (EN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    if (LOAD) begin
      q_d     = L;
      presc_d = '0;
      done_d  = 1'b0;
      state_d = RUN;
    end else if (tick && (state_q == RUN)) begin
      if (D) begin
        if (q_q < A) q_d = q_q + WIDTH'(1);
        else         terminal = 1'b1;
      end else begin
        if (q_q != '0) q_d = q_q - WIDTH'(1);
        else           terminal = 1'b1;
      end

      if (terminal) begin
        z_d = 1'b1;
        case (MODE)
          2'b01: ;
          2'b10: begin
            done_d  = 1'b1;
            state_d = STOP;
          end
          default: q_d = D ? '0 : B;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      q_q     <= '0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      state_q <= RUN;
      presc_q <= '0;
    end else begin
      q_q     <= q_d;
      z_q     <= z_d;
      done_q  <= done_d;
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  assign Q       = q_q;
  assign Z_carry = z_q;
  assign DONE    = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_counter_updn_param.sv
// Bench for counter_updn_param: directed vector table, a prescaler sequence and
// randomized cycles compared against a rule-level reference model.
module tb_counter_updn_param;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [3:0] l = '0, a = '0, b = '0;
  logic       d = 1'b1;
  logic [1:0] mode = 2'b00;

  logic [3:0] q1, q4;
  logic       z1, z4, done1, done4, st1, st4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_updn_param #(.WIDTH(4), .PRESCALE(1)) u_dut1 (
    .clk(clk), .reset_p(reset_p), .EN(en), .LOAD(load), .L(l), .A(a), .B(b),
    .D(d), .MODE(mode), .Q(q1), .Z_carry(z1), .DONE(done1), .state_o(st1)
  );

  counter_updn_param #(.WIDTH(4), .PRESCALE(4)) u_dut4 (
    .clk(clk), .reset_p(reset_p), .EN(en), .LOAD(load), .L(l), .A(a), .B(b),
    .D(d), .MODE(mode), .Q(q4), .Z_carry(z4), .DONE(done4), .state_o(st4)
  );

  // Reference model: counter value as a plain integer plus a "stopped" flag.
  typedef struct {
    int q;
    bit z;
    bit done;
    bit stopped;
    int en_count;
  } model_t;

  model_t m1, m4;

  function automatic model_t model_step(model_t s, int presc);
    model_t n = s;
    bit     fire;
    n.z = 1'b0;
    if (reset_p) begin
      n.q = 0; n.done = 0; n.stopped = 0; n.en_count = 0;
    end else if (load) begin
      n.q = int'(l); n.done = 0; n.stopped = 0; n.en_count = 0;
    end else begin
      fire = 1'b0;
      if (en) begin
        n.en_count = s.en_count + 1;
        if (n.en_count == presc) begin
          fire = 1'b1;
          n.en_count = 0;
        end
      end
      if (fire && !s.stopped) begin
        if (d && s.q < int'(a))       n.q = s.q + 1;
        else if (!d && s.q > 0)       n.q = s.q - 1;
        else begin
          n.z = 1'b1;
          if (mode == 2'd1) begin
          end else if (mode == 2'd2) begin
            n.done = 1'b1;
            n.stopped = 1'b1;
          end else begin
            n.q = d ? 0 : int'(b);
          end
        end
      end
    end
    return n;
  endfunction

  task automatic check(string name, logic [3:0] gq, logic gz, logic gd,
                       int eq, bit ez, bit ed);
    n_checks++;
    if (int'(gq) != eq || gz !== ez || gd !== ed) begin
      n_fail++;
      $display("FAIL %s: got Q=%0d Z_carry=%0b DONE=%0b, expected Q=%0d Z_carry=%0b DONE=%0b",
               name, gq, gz, gd, eq, ez, ed);
    end
  endtask

  // Inputs are applied 1 time unit after a rising edge; this advances one edge
  // and samples outputs 1 unit later, updating both models for that edge.
  task automatic step();
    @(posedge clk);
    m1 = model_step(m1, 1);
    m4 = model_step(m4, 4);
    #1;
  endtask

  typedef struct {
    bit       rst, en, load;
    bit [3:0] l, a, b;
    bit       d;
    bit [1:0] mode;
    int       eq;
    bit       ez, ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit r, bit e, bit ld, int lv, int av, int bv, bit dv, int md,
                     int eq, bit ez, bit ed);
    vec_t v;
    v.rst = r; v.en = e; v.load = ld;
    v.l = 4'(lv); v.a = 4'(av); v.b = 4'(bv);
    v.d = dv; v.mode = 2'(md);
    v.eq = eq; v.ez = ez; v.ed = ed;
    vecs.push_back(v);
  endtask

  initial begin
    // reset
    add(1,0,0, 0,5,3,1,0, 0,0,0);
    // wrap up to A=5
    for (int i = 1; i <= 5; i++) add(0,1,0, 0,5,3,1,0, i,0,0);
    add(0,1,0, 0,5,3,1,0, 0,1,0);
    add(0,1,0, 0,5,3,1,0, 1,0,0);
    // wrap down with B=3
    add(0,0,1, 1,5,3,0,0, 1,0,0);
    add(0,1,0, 0,5,3,0,0, 0,0,0);
    add(0,1,0, 0,5,3,0,0, 3,1,0);
    add(0,1,0, 0,5,3,0,0, 2,0,0);
    add(0,1,0, 0,5,3,0,0, 1,0,0);
    add(0,1,0, 0,5,3,0,0, 0,0,0);
    add(0,1,0, 0,5,3,0,0, 3,1,0);
    // saturate at A=2
    add(1,0,0, 0,2,3,1,1, 0,0,0);
    add(0,1,0, 0,2,3,1,1, 1,0,0);
    add(0,1,0, 0,2,3,1,1, 2,0,0);
    add(0,1,0, 0,2,3,1,1, 2,1,0);
    add(0,1,0, 0,2,3,1,1, 2,1,0);
    add(0,0,0, 0,2,3,1,1, 2,0,0);
    // one-shot at A=3, then frozen until LOAD
    add(1,0,0, 0,3,3,1,2, 0,0,0);
    add(0,1,0, 0,3,3,1,2, 1,0,0);
    add(0,1,0, 0,3,3,1,2, 2,0,0);
    add(0,1,0, 0,3,3,1,2, 3,0,0);
    add(0,1,0, 0,3,3,1,2, 3,1,1);
    add(0,1,0, 0,3,3,1,2, 3,0,1);
    add(0,1,0, 0,3,3,1,0, 3,0,1);
    add(0,1,0, 0,3,3,0,0, 3,0,1);
    add(0,1,1, 0,3,3,1,2, 0,0,0);
    add(0,1,0, 0,3,3,1,2, 1,0,0);
    // LOAD beats a terminal tick; reset beats LOAD
    add(0,0,1, 2,2,3,1,0, 2,0,0);
    add(0,1,1, 1,2,3,1,0, 1,0,0);
    add(1,1,1, 3,2,3,1,0, 0,0,0);
    // Q above A after load is terminal on the next up tick
    add(0,0,1, 7,3,3,1,0, 7,0,0);
    add(0,1,0, 0,3,3,1,0, 0,1,0);
    // A == 0 up and B == 0 down: every tick terminal
    add(0,1,0, 0,0,3,1,0, 0,1,0);
    add(0,1,0, 0,0,3,1,0, 0,1,0);
    add(0,1,0, 0,0,0,0,0, 0,1,0);
    add(0,1,0, 0,0,0,0,0, 0,1,0);
    add(0,1,0, 0,0,0,1,1, 0,1,0);
    add(0,0,0, 0,0,0,1,1, 0,0,0);
    // D change while idle does not alter Q; full-range wrap at 15
    add(0,0,1, 5,9,0,1,0, 5,0,0);
    add(0,0,0, 0,9,0,0,0, 5,0,0);
    add(0,0,0, 0,9,0,1,0, 5,0,0);
    add(0,0,1, 15,15,0,1,0, 15,0,0);
    add(0,1,0, 0,15,0,1,0, 0,1,0);
    add(0,1,0, 0,15,0,1,3, 1,0,0);
  end

  initial begin
    int pq[5];
    bit pe[5];
    #1;
    m1 = '{default: 0};
    m4 = '{default: 0};

    // Directed table against the PRESCALE=1 instance.
    foreach (vecs[i]) begin
      reset_p = vecs[i].rst; en = vecs[i].en; load = vecs[i].load;
      l = vecs[i].l; a = vecs[i].a; b = vecs[i].b;
      d = vecs[i].d; mode = vecs[i].mode;
      step();
      check($sformatf("vec%0d", i), q1, z1, done1, vecs[i].eq, vecs[i].ez, vecs[i].ed);
    end

    // PRESCALE=4: EN pattern 1,1,0,1,1 gives one increment, on the 4th enabled cycle.
    reset_p = 1'b1; load = 1'b0; en = 1'b0; d = 1'b1; mode = 2'b00; a = 4'd15;
    step();
    check("presc_reset", q4, z4, done4, 0, 0, 0);
    reset_p = 1'b0;
    pe = '{1, 1, 0, 1, 1};
    pq = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      en = pe[i];
      step();
      check($sformatf("presc_c%0d", i), q4, z4, done4, pq[i], 0, 0);
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("presc_second_tick", q4, z4, done4, 2, 0, 0);

    // Randomized cycles against the model, both prescale settings.
    reset_p = 1'b1;
    step();
    reset_p = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset_p = ($urandom_range(0, 99) == 0);
      load    = ($urandom_range(0, 15) == 0);
      en      = ($urandom_range(0, 3) != 0);
      l       = 4'($urandom_range(0, 15));
      a       = 4'($urandom_range(0, 15));
      b       = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) d = ~d;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      step();
      check("rand_p1", q1, z1, done1, m1.q, m1.z, m1.done);
      check("rand_p4", q4, z4, done4, m4.q, m4.z, m4.done);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_updn_param.md
COUNTER_UPDN_PARAM -- requirements
Module: counter_updn_param

Interface
REQ-001 Parameter WIDTH, default 4: bit width of counter, limits and load value; legal range 2..16.
REQ-002 Parameter PRESCALE, default 1: number of enabled cycles per count tick; legal range 1..256.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_p  input  1  reset, synchronous, active-high.
REQ-005 EN  input  1  count enable, active-high; gates the prescaler.
REQ-006 LOAD  input  1  synchronous load strobe, active-high.
REQ-007 L  input  WIDTH  load value.
REQ-008 A  input  WIDTH  up-count terminal value.
REQ-009 B  input  WIDTH  down-count reload value.
REQ-010 D  input  1  direction: 1 = up, 0 = down.
REQ-011 MODE  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-012 Q  output  WIDTH  count value, registered.
REQ-013 Z_carry  output  1  terminal-event pulse, registered, one cycle per event.
REQ-014 DONE  output  1  one-shot complete flag, registered.

Function
REQ-015 Count state is a single WIDTH-bit register driving Q in both directions; a change of D does not alter Q.
REQ-016 Prescaler counts 0..PRESCALE-1 on cycles with EN=1 and holds when EN=0; tick = EN & (prescaler == PRESCALE-1), prescaler then returns to 0; PRESCALE=1 gives tick = EN.
REQ-017 Priority per cycle: reset_p > LOAD > tick > hold.
REQ-018 LOAD: Q <= L, prescaler <= 0, Z_carry <= 0, DONE <= 0, FSM <= RUN, regardless of EN or FSM state.
REQ-019 FSM states RUN and STOP; ticks are ignored in STOP; only LOAD or reset_p exit STOP.
REQ-020 Up tick in RUN: Q < A gives Q <= Q+1, Z_carry <= 0; Q >= A is a terminal tick.
REQ-021 Down tick in RUN: Q > 0 gives Q <= Q-1, Z_carry <= 0; Q == 0 is a terminal tick.
REQ-022 Terminal tick, wrap mode: Q <= 0 (up) or Q <= B (down), Z_carry <= 1.
REQ-023 Terminal tick, saturate mode: Q holds, Z_carry <= 1 on every terminal tick.
REQ-024 Terminal tick, one-shot mode: Q holds, Z_carry <= 1, DONE <= 1, FSM <= STOP.
REQ-025 Z_carry is 0 in any cycle without a terminal tick; it never stays high two cycles unless terminal ticks occur on consecutive cycles.
REQ-026 A and B are sampled live at each tick; Q > A from a load or limit change counts as terminal on the next up tick.
REQ-027 A == 0 up: every tick is terminal; B == 0 down wrap: Q stays 0 and Z_carry pulses every tick.
REQ-028 Arithmetic is modulo 2^WIDTH internally, but REQ-020/021 guarantee Q never passes A (up) or 0 (down).
REQ-029 MODE changes take effect at the next tick; a change while in STOP has no effect until LOAD.

Reset
REQ-030 reset_p=1 at a rising edge sets Q=0, Z_carry=0, DONE=0, prescaler=0, FSM=RUN, overriding LOAD and EN.
REQ-031 Reset mid-count or in STOP takes effect at the same edge; outputs are valid from that edge.
REQ-032 Without a reset edge, outputs are undefined; no asynchronous path from reset_p.

Verification
REQ-033 WIDTH=4, PRESCALE=1, MODE=00, D=1, A=5, EN=1 after reset -> Q 1,2,3,4,5,0; Z_carry=1 only in the cycle Q becomes 0; pattern repeats.
REQ-034 MODE=00, D=0, B=3, LOAD with L=1 -> Q 1,0,3,2,1,0,3; Z_carry pulses with each return to 3.
REQ-035 MODE=01, D=1, A=2, from Q=0 -> Q 1,2,2,2; Z_carry=0 until Q reaches 2, then 1 on each further tick.
REQ-036 MODE=10, D=1, A=3, from Q=0 -> Q 1,2,3,3 then frozen; DONE=1 and Z_carry one pulse; further EN ignored; LOAD L=0 -> DONE=0, counting resumes.
REQ-037 PRESCALE=4, EN toggled 1,1,0,1,1 -> Q increments exactly once, on the fourth EN=1 cycle.
REQ-038 LOAD and terminal tick in the same cycle -> Q=L, Z_carry=0; reset_p with LOAD -> Q=0.
